game_sched_ctrl: RTL and testbench

Central game sequencer for the falling-fruit game. Replaces the per-object free-running clock dividers with single-clock move strobes, runs the round FSM (idle/play/pause/over) and the countdown timer, and accumulates the score from per-object catch pulses. It sits between the keyboard decoder and the object address generators. Those generators advance one step per move_en pulse and hide their sprite when obj_en is low.

---
 rtl/game_pkg.sv | 27 ++
 rtl/tick_gen.sv | 35 +++
 rtl/game_sched_ctrl.sv | 160 ++++++++++++++++
 tb/tb_game_sched_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the falling-fruit game sequencer: round states,
// object slot indices, point values and a counter-width helper.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int OBJ_BUG    = 0;
    localparam int OBJ_GREEN  = 1;
    localparam int OBJ_ORANGE = 2;
    localparam int OBJ_YELLOW = 3;

    localparam int PTS_YELLOW = 1;
    localparam int PTS_ORANGE = 2;
    localparam int PTS_GREEN  = 3;
    localparam int PEN_BUG    = 3;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-PERIOD strobe generator: counts while en, holds otherwise, clears on clr.
// shift divides the period by 2^shift; an effective period below one clamps to one.
module tick_gen #(
    parameter int WIDTH  = 8,
    parameter int PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       shift,
    output logic [WIDTH-1:0] count,
    output logic             pulse
);

    int               eff;
    logic [WIDTH-1:0] term;

    always_comb begin
        eff = PERIOD >> shift;
        if (eff < 1) eff = 1;
        term = WIDTH'(eff - 1);
    end

    // >= rather than == so a counter stranded above a freshly shortened period wraps at once
    assign pulse = en && (count >= term);

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en)
            count <= pulse ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/game_sched_ctrl.sv
// Round sequencer for the falling-fruit game: move strobes, round FSM, countdown and score.
// Optional macro SPEEDUP_EN halves fall periods every LEVEL_SEC seconds of play (up to level 3).
module game_sched_ctrl
    import game_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int GAME_SEC   = 60,
    parameter int PER_BUG    = 1048576,
    parameter int PER_GREEN  = 524288,
    parameter int PER_ORANGE = 1048576,
    parameter int PER_YELLOW = 2097152,
    parameter int SCORE_W    = 8,
    parameter int LEVEL_SEC  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic [3:0]         catch_valid,
    output logic [3:0]         move_en,
    output logic [3:0]         obj_en,
    output logic [1:0]         state,
    output logic [6:0]         time_left,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         level
);

    localparam int SW2 = SCORE_W + 2;
    localparam logic signed [SW2-1:0] SCORE_MAX = $signed({2'b00, {SCORE_W{1'b1}}});
    localparam logic signed [SW2-1:0] D_YEL = SW2'(PTS_YELLOW);
    localparam logic signed [SW2-1:0] D_ORA = SW2'(PTS_ORANGE);
    localparam logic signed [SW2-1:0] D_GRN = SW2'(PTS_GREEN);
    localparam logic signed [SW2-1:0] D_BUG = SW2'(PEN_BUG);

    if (GAME_SEC < 1 || GAME_SEC > 127 || LEVEL_SEC < 1) begin : g_cfg_err
        $error("game_sched_ctrl: GAME_SEC must be 1..127 and LEVEL_SEC at least 1");
    end

    function automatic logic [SCORE_W-1:0] sat_score(input logic signed [SW2-1:0] v);
        if (v < 0) return '0;
        if (v > SCORE_MAX) return '1;
        return v[SCORE_W-1:0];
    endfunction

    state_t             st;
    logic [6:0]         time_left_q;
    logic [SCORE_W-1:0] score_q;
    logic               play, active, start_round, sec_pulse;

    assign play        = (st == ST_PLAY);
    assign active      = play || (st == ST_PAUSE);
    assign start_round = start && !active;

    assign obj_en    = active ? 4'hF : 4'h0;
    assign state     = st;
    assign time_left = time_left_q;
    assign score     = score_q;

    logic [cnt_w(CLK_HZ)-1:0]     cnt_sec;
    logic [cnt_w(PER_BUG)-1:0]    cnt_bug;
    logic [cnt_w(PER_GREEN)-1:0]  cnt_green;
    logic [cnt_w(PER_ORANGE)-1:0] cnt_orange;
    logic [cnt_w(PER_YELLOW)-1:0] cnt_yellow;
    logic                         unused_cnt;

    assign unused_cnt = ^{cnt_sec, cnt_bug, cnt_green, cnt_orange, cnt_yellow};

    tick_gen #(.WIDTH(cnt_w(CLK_HZ)), .PERIOD(CLK_HZ)) u_sec (
        .clk(clk), .rst(rst), .en(play), .clr(!active), .shift(2'd0),
        .count(cnt_sec), .pulse(sec_pulse));

    tick_gen #(.WIDTH(cnt_w(PER_BUG)), .PERIOD(PER_BUG)) u_bug (
        .clk(clk), .rst(rst), .en(play), .clr(!active), .shift(level),
        .count(cnt_bug), .pulse(move_en[OBJ_BUG]));

    tick_gen #(.WIDTH(cnt_w(PER_GREEN)), .PERIOD(PER_GREEN)) u_green (
        .clk(clk), .rst(rst), .en(play), .clr(!active), .shift(level),
        .count(cnt_green), .pulse(move_en[OBJ_GREEN]));

    tick_gen #(.WIDTH(cnt_w(PER_ORANGE)), .PERIOD(PER_ORANGE)) u_orange (
        .clk(clk), .rst(rst), .en(play), .clr(!active), .shift(level),
        .count(cnt_orange), .pulse(move_en[OBJ_ORANGE]));

    tick_gen #(.WIDTH(cnt_w(PER_YELLOW)), .PERIOD(PER_YELLOW)) u_yellow (
        .clk(clk), .rst(rst), .en(play), .clr(!active), .shift(level),
        .count(cnt_yellow), .pulse(move_en[OBJ_YELLOW]));

    // Two guard bits keep the worst-case sum (max score + 6, or 0 - 3) representable
    logic signed [SW2-1:0] delta, sum;

    always_comb begin
        delta = '0;
        if (catch_valid[OBJ_YELLOW]) delta = delta + D_YEL;
        if (catch_valid[OBJ_ORANGE]) delta = delta + D_ORA;
        if (catch_valid[OBJ_GREEN])  delta = delta + D_GRN;
        if (catch_valid[OBJ_BUG])    delta = delta - D_BUG;
        sum = $signed({2'b00, score_q}) + delta;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= ST_IDLE;
            time_left_q <= '0;
            score_q     <= '0;
        end else begin
            case (st)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        st          <= ST_PLAY;
                        time_left_q <= 7'(GAME_SEC);
                        score_q     <= '0;
                    end
                end
                ST_PLAY: begin
                    score_q <= sat_score(sum);
                    if (sec_pulse && time_left_q != 7'd0)
                        time_left_q <= time_left_q - 7'd1;
                    // Expiry beats a simultaneous pause so the round cannot freeze at zero
                    if (sec_pulse && time_left_q <= 7'd1)
                        st <= ST_OVER;
                    else if (pause)
                        st <= ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (pause) st <= ST_PLAY;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

`ifdef SPEEDUP_EN
    localparam int LVL_W = cnt_w(LEVEL_SEC);

    logic [LVL_W-1:0] lvl_cnt;
    logic [1:0]       level_q;

    assign level = level_q;

    always_ff @(posedge clk) begin
        if (rst || start_round) begin
            lvl_cnt <= '0;
            level_q <= 2'd0;
        end else if (play && sec_pulse) begin
            if (lvl_cnt == LVL_W'(LEVEL_SEC - 1)) begin
                lvl_cnt <= '0;
                if (level_q != 2'd3) level_q <= level_q + 2'd1;
            end else begin
                lvl_cnt <= lvl_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_start_round;

    assign unused_start_round = start_round;
    assign level = 2'd0;
`endif

endmodule

// File: tb/tb_game_sched_ctrl.sv
// Directed bench for game_sched_ctrl with small periods (CLK_HZ=20, PER 4/2/4/8, GAME_SEC=3).
module tb_game_sched_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pause;
    logic [3:0] catch_valid;
    logic [3:0] move_en;
    logic [3:0] obj_en;
    logic [1:0] state;
    logic [6:0] time_left;
    logic [7:0] score;
    logic [1:0] level;

    int n_assert = 0;
    int n_fail   = 0;

    game_sched_ctrl #(
        .CLK_HZ(20), .GAME_SEC(3),
        .PER_BUG(4), .PER_GREEN(2), .PER_ORANGE(4), .PER_YELLOW(8),
        .SCORE_W(8), .LEVEL_SEC(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .catch_valid(catch_valid), .move_en(move_en), .obj_en(obj_en),
        .state(state), .time_left(time_left), .score(score), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Strobe pattern k cycles into play with base periods 4/2/4/8
    function automatic logic [3:0] move_model(input int k);
        logic [3:0] m;
        m[0] = (k % 4 == 3);
        m[1] = (k % 2 == 1);
        m[2] = (k % 4 == 3);
        m[3] = (k % 8 == 7);
        return m;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; catch_valid = 4'b0;
        adv(3);
        rst = 1'b0;
        adv(1);
        chk("rst_state", state, 0);
        chk("rst_score", score, 0);
        chk("rst_time", time_left, 0);
        chk("rst_move", move_en, 0);
        chk("rst_obj", obj_en, 0);
        chk("rst_level", level, 0);

        // Round 1: strobe cadence, pause/resume, floor and ignored start
        start = 1'b1; adv(1); start = 1'b0;
        chk("r1_state", state, 1);
        chk("r1_time", time_left, 3);
        chk("r1_obj", obj_en, 4'hF);
        for (int k = 0; k <= 5; k++) begin
            chk($sformatf("r1_move_p%0d", k), move_en, move_model(k));
            if (k < 5) adv(1);
        end
        pause = 1'b1; adv(1); pause = 1'b0;
        for (int c = 6; c <= 14; c++) begin
            chk($sformatf("pause_state_c%0d", c), state, 2);
            chk($sformatf("pause_move_c%0d", c), move_en, 0);
            chk($sformatf("pause_time_c%0d", c), time_left, 3);
            catch_valid = (c == 8) ? 4'b1110 : 4'b0000;
            adv(1);
        end
        catch_valid = 4'b0;
        chk("pause_catch_score", score, 0);
        chk("pause_obj", obj_en, 4'hF);
        pause = 1'b1; adv(1); pause = 1'b0;
        chk("resume_state", state, 1);
        chk("resume_move_p6", move_en, move_model(6));
        adv(1);
        chk("resume_move_p7", move_en, move_model(7));
        adv(1);
        catch_valid = 4'b0001; adv(1); catch_valid = 4'b0;
        chk("score_floor", score, 0);
        catch_valid = 4'b1110; adv(1); catch_valid = 4'b0;
        chk("score_plus6", score, 6);
        start = 1'b1; adv(1); start = 1'b0;
        chk("start_in_play_state", state, 1);
        chk("start_in_play_time", time_left, 3);
        chk("start_in_play_score", score, 6);
        adv(8);
        chk("time_p19", time_left, 3);
        adv(1);
        chk("time_p20", time_left, 2);
        adv(20);
        chk("time_p40", time_left, 1);
        adv(19);
        chk("state_p59", state, 1);
        chk("time_p59", time_left, 1);
        adv(1);
        chk("over_state", state, 3);
        chk("over_time", time_left, 0);
        chk("over_move", move_en, 0);
        chk("over_obj", obj_en, 0);
        adv(25);
        chk("over_hold_state", state, 3);
        chk("over_no_underflow", time_left, 0);
        chk("over_hold_move", move_en, 0);

        // Round 2: start beats pause from OVER, saturation, pause beats start in PLAY
        start = 1'b1; pause = 1'b1; adv(1); start = 1'b0; pause = 1'b0;
        chk("r2_state", state, 1);
        chk("r2_time", time_left, 3);
        chk("r2_score_clear", score, 0);
        catch_valid = 4'b1110; adv(42);
        chk("r2_score_252", score, 252);
        catch_valid = 4'b1000; adv(1);
        chk("r2_score_253", score, 253);
        catch_valid = 4'b0010; adv(1);
        chk("r2_score_sat", score, 255);
        catch_valid = 4'b1000; adv(1);
        chk("r2_score_sat_hold", score, 255);
        catch_valid = 4'b0001; adv(1); catch_valid = 4'b0;
        chk("r2_score_minus3", score, 252);
        chk("r2_time_p46", time_left, 1);
`ifndef SPEEDUP_EN
        chk("r2_level_fixed", level, 0);
`endif
        start = 1'b1; pause = 1'b1; adv(1); start = 1'b0; pause = 1'b0;
        chk("play_start_pause_state", state, 2);
        chk("play_start_pause_score", score, 252);
        rst = 1'b1; adv(1); rst = 1'b0;
        chk("midrst_state", state, 0);
        chk("midrst_score", score, 0);
        chk("midrst_time", time_left, 0);
        chk("midrst_obj", obj_en, 0);

`ifdef SPEEDUP_EN
        // Round 3: one level per second, yellow period 8 -> 4 after first second
        start = 1'b1; adv(1); start = 1'b0;
        adv(19);
        chk("spd_level_p19", level, 0);
        adv(1);
        chk("spd_level_p20", level, 1);
        chk("spd_yellow_p20", move_en[3], 1);
        adv(1);
        chk("spd_yellow_p21", move_en[3], 0);
        adv(3);
        chk("spd_yellow_p24", move_en[3], 1);
        adv(16);
        chk("spd_level_p40", level, 2);
        adv(20);
        chk("spd_over_state", state, 3);
        chk("spd_level_sat", level, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
